// File: rtl/cdc_hs_tx_ctrl.sv
// Source side of a 4-phase REQ/ACK word transfer across clock domains.
// Optional handshake timeout: define CDC_HS_TIMEOUT_EN.
module cdc_hs_tx_ctrl #(
  parameter int W           = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TO_CYCLES   = 1024
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic         CE,
  input  logic         IN_VALID,
  input  logic [W-1:0] IN_DATA,
  output logic         IN_READY,
  output logic [W-1:0] TX_DATA,
  output logic         REQ,
  input  logic         ACK_ASYNC,
  output logic         BUSY,
  output logic         DONE,
  output logic         ERR
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TO_CYCLES < 2)
  begin : g_param_chk
    $error("cdc_hs_tx_ctrl: illegal parameters");
  end

  typedef enum logic [1:0] {
    IDLE,
    REQ_HI,
    REQ_LO
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;

  assign ack_s    = sync_q[SYNC_STAGES-1];
  assign IN_READY = (state == IDLE) && !ack_s;
  assign BUSY     = (state != IDLE);

`ifdef CDC_HS_TIMEOUT_EN
  localparam int CW = (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;

  logic [CW-1:0] cnt;
  logic          err_q;
  logic          to_hit;

  assign to_hit = BUSY && (cnt == CW'(TO_CYCLES - 1));
  assign ERR    = err_q;
`else
  assign ERR = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state   <= IDLE;
      REQ     <= 1'b0;
      TX_DATA <= '0;
      DONE    <= 1'b0;
      sync_q  <= '0;
`ifdef CDC_HS_TIMEOUT_EN
      cnt     <= '0;
      err_q   <= 1'b0;
`endif
    end else if (CE) begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ACK_ASYNC};
      DONE   <= 1'b0;
`ifdef CDC_HS_TIMEOUT_EN
      cnt    <= BUSY ? cnt + 1'b1 : '0;
`endif
      unique case (state)
        IDLE: begin
          if (IN_VALID && IN_READY) begin
            TX_DATA <= IN_DATA;
            REQ     <= 1'b1;
            state   <= REQ_HI;
          end
        end
        REQ_HI: begin
          if (ack_s) begin
            REQ   <= 1'b0;
            state <= REQ_LO;
`ifdef CDC_HS_TIMEOUT_EN
            cnt   <= '0;
`endif
          end
        end
        REQ_LO: begin
          if (!ack_s) begin
            DONE  <= 1'b1;
            state <= IDLE;
`ifdef CDC_HS_TIMEOUT_EN
            cnt   <= '0;
`endif
          end
        end
        default: begin
          REQ   <= 1'b0;
          state <= IDLE;
        end
      endcase
`ifdef CDC_HS_TIMEOUT_EN
      // Abort wins over any handshake progress this edge.
      if (to_hit) begin
        err_q <= 1'b1;
        REQ   <= 1'b0;
        DONE  <= 1'b0;
        cnt   <= '0;
        state <= IDLE;
      end
`endif
    end
  end

endmodule

// File: tb/tb_cdc_hs_tx_ctrl.sv
// Directed bench for cdc_hs_tx_ctrl with a word scoreboard.
// Build with CDC_HS_TIMEOUT_EN to exercise the timeout path.
module tb_cdc_hs_tx_ctrl;
  localparam int W  = 8;
  localparam int SS = 2;
  localparam int TO = 16;

  logic         CLK = 1'b0;
  logic         RSTn;
  logic         CE;
  logic         IN_VALID;
  logic [W-1:0] IN_DATA;
  logic         IN_READY;
  logic [W-1:0] TX_DATA;
  logic         REQ;
  logic         ACK_ASYNC;
  logic         BUSY;
  logic         DONE;
  logic         ERR;

  int           nevals = 0;
  int           nfail  = 0;
  logic [W-1:0] sb[$];

  always #5 CLK = ~CLK;

  cdc_hs_tx_ctrl #(
    .W(W),
    .SYNC_STAGES(SS),
    .TO_CYCLES(TO)
  ) dut (
    .CLK(CLK),
    .RSTn(RSTn),
    .CE(CE),
    .IN_VALID(IN_VALID),
    .IN_DATA(IN_DATA),
    .IN_READY(IN_READY),
    .TX_DATA(TX_DATA),
    .REQ(REQ),
    .ACK_ASYNC(ACK_ASYNC),
    .BUSY(BUSY),
    .DONE(DONE),
    .ERR(ERR)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    nevals++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_accept(string tag);
    logic [W-1:0] e;
    e = (sb.size() != 0) ? sb.pop_front() : 'x;
    chk({tag, "_req"}, REQ, 1);
    chk({tag, "_tx"}, TX_DATA, e);
  endtask

  // Steps until REQ falls (or DONE rises), TX_DATA must hold.
  task automatic wait_for(string tag, bit want_done,
                          logic [W-1:0] tx);
    int n;
    n = 0;
    do begin
      step();
      n++;
      chk({tag, "_hold"}, TX_DATA, tx);
    end while ((want_done ? !DONE : REQ) && n < 20);
    if (want_done) chk({tag, "_done"}, DONE, 1);
    else chk({tag, "_reqlo"}, REQ, 0);
  endtask

  task automatic finish_xfer(string tag, logic [W-1:0] tx);
    ACK_ASYNC = 1'b1;
    wait_for({tag, "_a"}, 1'b0, tx);
    ACK_ASYNC = 1'b0;
    wait_for({tag, "_b"}, 1'b1, tx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    RSTn      = 1'b0;
    CE        = 1'b1;
    IN_VALID  = 1'b0;
    IN_DATA   = '0;
    ACK_ASYNC = 1'b0;
    step();
    chk("rst_req", REQ, 0);
    chk("rst_tx", TX_DATA, 0);
    chk("rst_done", DONE, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_err", ERR, 0);
    chk("rst_rdy", IN_READY, 1);
    RSTn = 1'b1;

    // Basic transfer, edge-accurate handshake
    IN_VALID = 1'b1;
    IN_DATA  = 8'hA5;
    sb.push_back(8'hA5);
    step();
    chk_accept("t1");
    chk("t1_rdy", IN_READY, 0);
    chk("t1_busy", BUSY, 1);
    IN_VALID = 1'b0;
    repeat (3) step();
    ACK_ASYNC = 1'b1;
    step();
    step();
    chk("t2_req5", REQ, 1);
    step();
    chk("t2_req6", REQ, 0);
    step();
    step();
    ACK_ASYNC = 1'b0;
    step();
    step();
    chk("t2_done10", DONE, 0);
    chk("t2_busy10", BUSY, 1);
    step();
    chk("t2_done11", DONE, 1);
    chk("t2_rdy11", IN_READY, 1);
    chk("t2_busy11", BUSY, 0);
    chk("t2_tx11", TX_DATA, 8'hA5);
    step();
    chk("t2_done12", DONE, 0);

    // Back-to-back words
    sb.push_back(8'h01);
    sb.push_back(8'h02);
    IN_VALID = 1'b1;
    IN_DATA  = 8'h01;
    step();
    chk_accept("t3a");
    IN_DATA = 8'h02;
    finish_xfer("t3a", 8'h01);
    chk("t3_rdy", IN_READY, 1);
    step();
    chk_accept("t3b");
    IN_VALID = 1'b0;
    finish_xfer("t3b", 8'h02);

    // Stale ACK across reset release
    ACK_ASYNC = 1'b1;
    RSTn      = 1'b0;
    step();
    RSTn = 1'b1;
    chk("t4_rst_req", REQ, 0);
    step();
    step();
    chk("t4_rdy_stale", IN_READY, 0);
    IN_VALID = 1'b1;
    IN_DATA  = 8'h33;
    sb.push_back(8'h33);
    repeat (3) begin
      step();
      chk("t4_req_blk", REQ, 0);
      chk("t4_rdy_blk", IN_READY, 0);
    end
    ACK_ASYNC = 1'b0;
    step();
    chk("t4_rdy_1", IN_READY, 0);
    step();
    chk("t4_rdy_2", IN_READY, 1);
    chk("t4_req_2", REQ, 0);
    step();
    chk_accept("t4");
    IN_VALID = 1'b0;
    finish_xfer("t4", 8'h33);

    // CE gating in REQ_HI, DONE hold under CE=0
    IN_VALID = 1'b1;
    IN_DATA  = 8'h5C;
    sb.push_back(8'h5C);
    step();
    chk_accept("t5");
    IN_VALID  = 1'b0;
    ACK_ASYNC = 1'b1;
    step();
    chk("t5_req_pre", REQ, 1);
    CE = 1'b0;
    repeat (5) begin
      step();
      chk("t5_req_gated", REQ, 1);
    end
    CE = 1'b1;
    step();
    chk("t5_req_ce1", REQ, 1);
    step();
    chk("t5_req_ce2", REQ, 0);
    ACK_ASYNC = 1'b0;
    wait_for("t5", 1'b1, 8'h5C);
    CE = 1'b0;
    step();
    chk("t5_done_hold", DONE, 1);
    CE = 1'b1;
    step();
    chk("t5_done_clr", DONE, 0);

    // Reset mid-transfer
    IN_VALID = 1'b1;
    IN_DATA  = 8'h77;
    sb.push_back(8'h77);
    step();
    chk_accept("t5r");
    IN_VALID = 1'b0;
    step();
    RSTn = 1'b0;
    step();
    RSTn = 1'b1;
    chk("t5r_req", REQ, 0);
    chk("t5r_tx", TX_DATA, 0);
    chk("t5r_busy", BUSY, 0);

    // Timeout with ACK never raised
    IN_VALID = 1'b1;
    IN_DATA  = 8'h99;
    sb.push_back(8'h99);
    step();
    chk_accept("t6");
    IN_VALID = 1'b0;
`ifdef CDC_HS_TIMEOUT_EN
    for (int k = 1; k < TO; k++) begin
      step();
      chk("t6_req_wait", REQ, 1);
      chk("t6_err_wait", ERR, 0);
      chk("t6_done_wait", DONE, 0);
    end
    step();
    chk("t6_err", ERR, 1);
    chk("t6_req", REQ, 0);
    chk("t6_busy", BUSY, 0);
    chk("t6_done", DONE, 0);
    step();
    chk("t6_err_sticky", ERR, 1);
    chk("t6_done_after", DONE, 0);
`else
    for (int k = 0; k < 100; k++) begin
      step();
      chk("t6_req_hold", REQ, 1);
      chk("t6_err_zero", ERR, 0);
      chk("t6_done_zero", DONE, 0);
    end
`endif
    RSTn = 1'b0;
    step();
    RSTn = 1'b1;
    chk("end_req", REQ, 0);
    chk("end_sb", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nevals, nfail);
    $finish;
  end

endmodule
